// File: rtl/alu_system_sequencer.sv
// alu_system_sequencer: control unit emitting the ALU_System control word each cycle.
// Fetches a 16-bit instruction as two byte reads into IR, then executes it.
// Ports: Clock, Reset (sync, active-high), IROut[15:0], ALUOutFlag[3:0] {Z,C,N,O},
//        Ctrl_Word[40:0], State[2:0], Halted, Illegal.
// Optional: define SEQ_SINGLE_STEP_EN to add the Step input that gates each fetch.
module alu_system_sequencer #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        Clock,
    input  logic        Reset,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        Step,
`endif
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [40:0] Ctrl_Word,
    output logic [2:0]  State,
    output logic        Halted,
    output logic        Illegal
);
    typedef enum logic [2:0] {INIT, FETCH_L, FETCH_H, EXEC1, EXEC2, HALT} state_t;
    state_t st;
    logic go;
`ifdef SEQ_SINGLE_STEP_EN
    assign go = Step;
`else
    assign go = 1'b1;
`endif
    logic [3:0] op;
    logic [1:0] rx, rs;
    logic [3:0] rx_oh;
    logic unused_flags;
    assign op = IROut[15:12];
    assign rx = IROut[11:10];
    assign rs = IROut[9:8];
    assign rx_oh = 4'b1000 >> rx;
    assign unused_flags = ^ALUOutFlag[2:0];
    always_ff @(posedge Clock) begin
        if (Reset) st <= INIT;
        else case (st)
            INIT:    st <= FETCH_L;
            FETCH_L: st <= go ? FETCH_H : FETCH_L;
            FETCH_H: st <= EXEC1;
            EXEC1:   st <= (op == 4'h1 || op == 4'h2) ? EXEC2 : (op == 4'hF) ? HALT : FETCH_L;
            EXEC2:   st <= FETCH_L;
            HALT:    st <= HALT;
            default: st <= INIT;
        endcase
    end
    logic [2:0] out_a, out_b;
    logic [1:0] rf_fun, out_d, arf_fun, ir_fun, mux_a, mux_b;
    logic [3:0] rf_rsel, alu_fun, arf_rsel;
    logic ir_lh, ir_en, mem_wr, mem_cs, ill;
    always_comb begin
        out_a = 3'b000;
        out_b = 3'b000;
        rf_fun = 2'b00;
        rf_rsel = 4'b0000;
        alu_fun = 4'b0000;
        out_d = 2'b00;
        arf_fun = 2'b00;
        arf_rsel = 4'b0000;
        ir_lh = 1'b0;
        ir_en = 1'b0;
        ir_fun = 2'b00;
        mem_wr = 1'b0;
        mem_cs = 1'b1;
        mux_a = 2'b00;
        mux_b = 2'b00;
        ill = 1'b0;
        case (st)
            INIT: begin
                // A zero reset vector is a plain clear; otherwise PC is loaded from the ARF input.
                arf_fun = (PC_RESET == 8'h00) ? 2'b11 : 2'b10;
                arf_rsel = 4'b1000;
            end
            FETCH_L, FETCH_H: if (go || st == FETCH_H) begin
                mem_cs = 1'b0;
                out_d = 2'b11;
                ir_en = 1'b1;
                ir_fun = 2'b10;
                ir_lh = (st == FETCH_H);
                arf_fun = 2'b01;
                arf_rsel = 4'b1000;
            end
            EXEC1: case (op)
                4'h0: begin
                    rf_fun = 2'b10;
                    rf_rsel = rx_oh;
                    mux_a = 2'b10;
                end
                4'h1, 4'h2: begin
                    arf_fun = 2'b10;
                    arf_rsel = 4'b0100;
                    mux_b = 2'b10;
                end
                4'h3: begin
                    rf_fun = 2'b01;
                    rf_rsel = rx_oh;
                end
                4'h4: rf_rsel = rx_oh;
                4'h5: begin
                    out_a = {1'b0, rx};
                    out_b = {1'b0, rs};
                    alu_fun = 4'b0100;
                    rf_fun = 2'b10;
                    rf_rsel = rx_oh;
                end
                4'h6, 4'h7: if (op == 4'h6 || ALUOutFlag[3]) begin
                    arf_fun = 2'b10;
                    arf_rsel = 4'b1000;
                    mux_b = 2'b10;
                end
                4'hF: ;
                default: ill = 1'b1;
            endcase
            EXEC2: begin
                mem_cs = 1'b0;
                if (op == 4'h1) begin
                    mux_a = 2'b01;
                    rf_fun = 2'b10;
                    rf_rsel = rx_oh;
                end else begin
                    out_a = {1'b0, rx};
                    mem_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end
    assign Ctrl_Word = {out_a, out_b, rf_fun, rf_rsel, 4'b0000, alu_fun, 2'b00, out_d,
                        arf_fun, arf_rsel, ir_lh, ir_en, ir_fun, mem_wr, mem_cs, mux_a, mux_b, 1'b0};
    assign State = st;
    assign Halted = (st == HALT);
    assign Illegal = ill;
endmodule
